// File: rtl/mem_stage_pkg.sv
// Shared types for the memory access stage: FSM state, default widths and
// the holding-register record for an outstanding load/store.
// Holding-register widths follow DEF_DATA_W/DEF_REG_W.
package mem_stage_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Everything needed to drive the memory and finish the writeback once the
  // EX/MEM register has moved on.
  typedef struct packed {
    logic                  we;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  wbs;
    logic [DEF_REG_W-1:0]  dest;
  } mem_req_t;

endpackage

// File: rtl/access_watchdog.sv
// Counts cycles spent waiting on a memory access and flags the last allowed one.
// Latency: expired is combinational from the count on the TIMEOUT-th counted cycle.
// Backpressure: none; load clears the count, count_en advances it (saturating).
// Ports: clk, rst_n, load (clear), count_en (advance), expired (abort this cycle).
module access_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed waiting cycles, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign expired = count_en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: ALU results pass to MEM/WB, loads/stores go over dmem req/ack.
// Latency: ALU op 1 cycle; load/store 1 accept cycle + cycles to ack, result the edge after ack.
// Backpressure: stall_out holds EX/MEM while an access is outstanding; drops on ack/abort.
// Ports: EX/MEM fields (valid_in, wbs_in, mm_in, wm_in, ALUresult_in, store_data_in,
//        reg_dest_in), dmem_* handshake, MEM/WB outputs, stall_out, sticky timeout_err.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              wbs_in,
  input  logic              mm_in,
  input  logic              wm_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid_out,
  output logic              wbs_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_W-1:0]  reg_dest_out,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  mem_req_t          hold_q, hold_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wbs_q, wbs_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  reg_dest_q, reg_dest_d;
  logic              timeout_err_q, timeout_err_d;
  logic              mem_op;
  logic              expired;

  assign mem_op = valid_in && (mm_in || wm_in);

  access_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == IDLE),
    .count_en (state_q == ACCESS),
    .expired  (expired)
  );

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    wb_valid_d    = wb_valid_q;
    wbs_d         = wbs_q;
    wb_data_d     = wb_data_q;
    reg_dest_d    = reg_dest_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          wb_valid_d = 1'b0;
          wbs_d      = 1'b0;
        end else if (!mem_op) begin
          wb_valid_d = 1'b1;
          wbs_d      = wbs_in;
          wb_data_d  = ALUresult_in;
          reg_dest_d = reg_dest_in;
        end else begin
          // Store wins over load when both flags are set: no writeback.
          hold_d.we    = wm_in;
          hold_d.addr  = ALUresult_in;
          hold_d.wdata = store_data_in;
          hold_d.wbs   = wbs_in && !wm_in;
          hold_d.dest  = reg_dest_in;
          wb_valid_d   = 1'b0;
          wbs_d        = 1'b0;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          // An ack on the abort cycle still completes the access normally.
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          reg_dest_d = hold_q.dest;
          wbs_d      = hold_q.we ? 1'b0 : hold_q.wbs;
          wb_data_d  = hold_q.we ? hold_q.addr : dmem_rdata;
        end else if (expired) begin
          // Abort: emit a non-writing bubble so the pipeline keeps its slot count.
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          wb_valid_d    = 1'b1;
          wbs_d         = 1'b0;
          wb_data_d     = hold_q.addr;
          reg_dest_d    = hold_q.dest;
        end else begin
          wb_valid_d = 1'b0;
          wbs_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      wb_valid_q    <= 1'b0;
      wbs_q         <= 1'b0;
      wb_data_q     <= '0;
      reg_dest_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      wb_valid_q    <= wb_valid_d;
      wbs_q         <= wbs_d;
      wb_data_q     <= wb_data_d;
      reg_dest_q    <= reg_dest_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Stall is gated by rst_n so it drops immediately while reset is held.
  always_comb begin
    stall_out = 1'b0;
    if (state_q == IDLE) begin
      stall_out = rst_n && mem_op;
    end else begin
      stall_out = !(dmem_ack || expired);
    end
  end

  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = hold_q.we;
  assign dmem_addr    = hold_q.addr;
  assign dmem_wdata   = hold_q.wdata;
  assign wb_valid_out = wb_valid_q;
  assign wbs_out      = wbs_q;
  assign wb_data_out  = wb_data_q;
  assign reg_dest_out = reg_dest_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;

  localparam int TIMEOUT = 15;
  localparam int NV      = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, wbs_in = 1'b0, mm_in = 1'b0, wm_in = 1'b0;
  logic [15:0] ALUresult_in = '0, store_data_in = '0;
  logic [4:0]  reg_dest_in = '0;
  logic        stall_out, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        wb_valid_out, wbs_out;
  logic [15:0] wb_data_out;
  logic [4:0]  reg_dest_out;
  logic        timeout_err;

  memory_access_stage #(.DATA_W(16), .REG_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .wbs_in(wbs_in),
    .mm_in(mm_in), .wm_in(wm_in), .ALUresult_in(ALUresult_in),
    .store_data_in(store_data_in), .reg_dest_in(reg_dest_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid_out(wb_valid_out), .wbs_out(wbs_out),
    .wb_data_out(wb_data_out), .reg_dest_out(reg_dest_out),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // dly: ACCESS cycles without ack before the ack cycle; -1 = never ack.
  typedef struct {
    logic        mm, wm, wbs;
    logic [15:0] alu, sd, rdata;
    logic [4:0]  dest;
    int          dly;
    logic        e_wbs;
    logic [15:0] e_data;
  } vec_t;

  typedef struct {
    logic        wbs;
    logic [15:0] data;
    logic [4:0]  dest;
    logic        chk_data;
  } exp_t;

  vec_t tbl[NV];
  vec_t v_to;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mem_ops = 0;
  int   req_starts = 0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every MEM/WB slot must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && wb_valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 expected no result at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_wbs", wbs_out, e.wbs);
        chk("wb_dest", reg_dest_out, e.dest);
        if (e.chk_data) chk("wb_data", wb_data_out, e.data);
      end
    end
  end

  // Each distinct request must begin with a rising dmem_req.
  always @(negedge clk) begin
    if (dmem_req && !prev_req) req_starts++;
    prev_req = dmem_req;
  end

  task automatic idle(input int n);
    valid_in = 1'b0; mm_in = 1'b0; wm_in = 1'b0; wbs_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Present one instruction at posedge+1; returns at posedge+1 once accepted.
  task automatic do_op(input vec_t v);
    exp_t e;
    int   req_n, stall_n, exp_n;
    bit   done;
    valid_in = 1'b1; wbs_in = v.wbs; mm_in = v.mm; wm_in = v.wm;
    ALUresult_in = v.alu; store_data_in = v.sd; reg_dest_in = v.dest;
    e.wbs = v.e_wbs; e.data = v.e_data; e.dest = v.dest; e.chk_data = (v.dly >= 0);
    sb.push_back(e);
    if (!(v.mm || v.wm)) begin
      @(negedge clk);
      chk("alu_stall", stall_out, 1'b0);
      @(posedge clk); #1;
      return;
    end
    mem_ops++;
    @(negedge clk);
    chk("accept_stall", stall_out, 1'b1);
    chk("accept_req", dmem_req, 1'b0);
    @(posedge clk); #1;
    req_n = 0; stall_n = 1; done = 1'b0;
    for (int k = 0; k < TIMEOUT + 5 && !done; k++) begin
      dmem_ack = (k == v.dly);
      dmem_rdata = v.rdata;
      @(negedge clk);
      if (dmem_req) begin
        req_n++;
        if (stall_out) stall_n++;
        chk("req_addr", dmem_addr, v.alu);
        chk("req_we", dmem_we, v.wm);
        if (v.wm) chk("req_wdata", dmem_wdata, v.sd);
      end
      if (!dmem_req || dmem_ack || !stall_out) done = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    exp_n = (v.dly < 0) ? TIMEOUT : v.dly + 1;
    chk("req_cycles", req_n, exp_n);
    chk("stall_cycles", stall_n, exp_n);
  endtask

  initial begin
    //            mm    wm    wbs   alu       sd        rdata     dest   dly e_wbs e_data
    tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 5'd5,  0, 1'b1, 16'h1234};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'hBEEF, 5'd7,  2, 1'b1, 16'hBEEF};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h00AA, 16'h0000, 5'd3,  0, 1'b0, 16'h0010};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 5'd0,  0, 1'b0, 16'h00FF};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555, 16'h9999, 5'd9,  1, 1'b0, 16'h0020};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'hCAFE, 5'd31, 0, 1'b1, 16'hCAFE};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 16'hA5A5, 16'h0000, 16'h0000, 5'd12, 0, 1'b1, 16'hA5A5};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'h0200, 16'h1111, 16'h0000, 5'd4,  3, 1'b0, 16'h0200};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h7777, 5'd6,  4, 1'b0, 16'h7777};
    v_to   = '{1'b1, 1'b0, 1'b1, 16'h0400, 16'h0000, 16'h0000, 5'd8, -1, 1'b0, 16'h0000};

    // Reset state
    #3;
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 16'h0);
    chk("rst_wb_valid", wb_valid_out, 1'b0);
    chk("rst_wb_data", wb_data_out, 16'h0);
    chk("rst_timeout", timeout_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // ALU op, load with 3 request cycles, store acked at once then ALU next cycle
    do_op(tbl[0]); idle(2);
    do_op(tbl[1]); idle(2);
    do_op(tbl[2]); do_op(tbl[3]); do_op(tbl[4]); idle(2);
    chk("no_timeout_yet", timeout_err, 1'b0);

    // Load never acked: abort after TIMEOUT request cycles, sticky error
    do_op(v_to); idle(2);
    chk("timeout_set", timeout_err, 1'b1);
    do_op(tbl[6]); idle(2);
    chk("timeout_sticky", timeout_err, 1'b1);

    // Reset in the middle of an access
    valid_in = 1'b1; mm_in = 1'b1; wm_in = 1'b0; wbs_in = 1'b1;
    ALUresult_in = 16'h0500; reg_dest_in = 5'd2;
    mem_ops++;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 1'b0);
    chk("midrst_stall", stall_out, 1'b0);
    chk("midrst_wb_valid", wb_valid_out, 1'b0);
    chk("midrst_timeout", timeout_err, 1'b0);
    valid_in = 1'b0; mm_in = 1'b0; wbs_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    do_op(tbl[0]); idle(2);

    // Back-to-back stream with random ack delays
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NV; i++) begin
        vec_t v;
        v = tbl[i];
        v.dly = int'($urandom_range(0, 4));
        do_op(v);
      end
    end
    idle(3);

    chk("sb_empty", sb.size(), 0);
    chk("no_dup_req", req_starts, mem_ops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound so a stuck handshake still ends the run.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
